expansion_timer: RTL and testbench
==================================

// Module: expansion_timer
// PURPOSE
// - Programmable 16-bit countdown timer expansion card; IO-bus responder beside expansion_uart.
// - Datapath is the initiator: drives i_ioSelect/i_ioAddress/i_ioNOE/i_ioNWE and i_bus.
// - This block answers through o_bus/o_busNOE and flags expiry on o_irq.
// - Register file of 8 bytes at BASE_ADDR: prescaler, reload, count snapshot, sticky status.
// PARAMETERS
// - BASE_ADDR  8'h10  first IO address of the 8-byte window; must be 8-aligned.
// PORTS
// - i_clkDesign   in   1  design clock, the only clock; all state on rising edge.
// - i_resetn      in   1  asynchronous, active-low reset.
// - i_bus         in   8  write data from datapath.
// - o_bus         out  8  read data; 8'h00 whenever o_busNOE=1.
// - o_busNOE      out  1  active-low read-data drive enable.
// - i_ioSelect    in   1  high = IO cycle in progress.
// - i_ioAddress   in   8  IO address.
// - i_ioNOE       in   1  active-low read strobe.
// - i_ioNWE       in   1  active-low write strobe.
// - o_irq         out  1  registered: STATUS.EXPIRED & CTRL.IRQEN.
// BEHAVIOUR
// - Reset: all registers 0, count 0, prescaler 0, o_irq 0, o_busNOE 1, o_bus 0.
// - hit = i_ioSelect & (i_ioAddress[7:3] == BASE_ADDR[7:3]); off = i_ioAddress[2:0].
// - Read: o_busNOE = ~(hit & ~i_ioNOE), combinational, zero latency; o_bus muxed by off.
// - Write: strobe edges detected on a registered copy of i_ioNWE.
//   - Commits once, in the first clock where hit & ~i_ioNWE and the previous sample was 1.
//   - A held strobe never re-commits.
// - Read side effects fire once, in the first clock after i_ioNOE returns 1, using the last in-strobe offset.
// - Map:
//   - 0 CTRL RW: [0] EN, [1] AUTORELOAD, [2] IRQEN, [7:3] read 0.
//   - 1 PRESC RW.
//   - 2 RELOAD_LO RW.
//   - 3 RELOAD_HI RW.
//   - 4 COUNT_LO R: snapshot.
//   - 5 COUNT_HI R.
//   - 6 STATUS R: [0] EXPIRED, [1] OVERRUN.
//   - 7 CMD W: any value restarts the counter; reads 0.
//   - Writes to 4..6 are ignored.
// - Prescaler (EN=1): pcnt counts 0..PRESC, then wraps to 0 and emits a 1-clock tick.
//   - Tick period = PRESC+1 clocks.
//   - EN=0 freezes pcnt and count.
// - On tick:
//   - count!=0: count <= count-1; count==1 sets EXPIRED. If EXPIRED is already set, OVERRUN is also set.
//   - count==0 & AUTORELOAD: count <= RELOAD.
//   - count==0 & ~AUTORELOAD: hold.
//   - Autoreload period = RELOAD+1 ticks. RELOAD=0 never expires.
// - CMD write: count <= RELOAD, pcnt <= 0. Wins over a tick in the same clock.
// - Snapshot (atomic 16-bit read):
//   - snap <= count every clock, except while a read strobe on off 4 is active (frozen).
//   - At the end of an off-4 read: snapHi <= snap[15:8]. Off 5 returns snapHi.
// - STATUS clear: end of an off-6 read clears EXPIRED and OVERRUN.
//   - An expiry in the same clock as the clear wins: EXPIRED=1, OVERRUN unchanged from its pre-clear value.
// - Reset mid-strobe or mid-count: immediate return to reset values. The edge detector reloads to 1, so a strobe still low after reset does not commit.
// STRUCTURE
// - Shared header expansion_defs.vh: offset constants TMR_CTRL..TMR_CMD and CTRL/STATUS bit indices.
// - Sub-module timer_core: prescaler + 16-bit counter.
//   - Inputs: en, autoreload, presc, reload, restart.
//   - Outputs: count, expire_pulse.
// - Top holds bus decode, strobe edge detectors, registers, snapshot and status.
// TESTING
// - Reset: after reset, read off 0,6 -> 8'h00. o_busNOE=1, o_irq=0 while idle.
// - Periodic expiry:
//   - Stimulus: PRESC=3, RELOAD=16'h0005, CTRL=8'h07, CMD.
//   - Response: EXPIRED and o_irq rise 20 clocks after the CMD commit, then expire again every 24 clocks.
// - Status/overrun:
//   - Stimulus: let two expiries pass unread, then read STATUS.
//   - Response: read returns 8'h03. The next read returns 8'h00 and o_irq drops the clock after the strobe ends.
// - Atomic read: with count crossing 16'h0100 -> 16'h00FF between the off-4 and off-5 reads, the pair returns {8'h01, 8'h00}.
// - Strobe and decode:
//   - CMD strobe held low 10 clocks -> one restart only.
//   - Address BASE_ADDR+8 or i_ioSelect=0 -> o_busNOE stays 1 and no register changes.
// - Async reset: assert i_resetn=0 mid-count, no clock edge -> o_irq=0, o_busNOE=1 immediately; registers read 0 afterwards.

Source files
------------

// File: rtl/expansion_timer_pkg.sv
// Shared definitions for the expansion timer card: register offsets, CTRL/STATUS bit
// positions and the CTRL register layout.
package expansion_timer_pkg;

    localparam logic [2:0] TMR_CTRL      = 3'd0;
    localparam logic [2:0] TMR_PRESC     = 3'd1;
    localparam logic [2:0] TMR_RELOAD_LO = 3'd2;
    localparam logic [2:0] TMR_RELOAD_HI = 3'd3;
    localparam logic [2:0] TMR_COUNT_LO  = 3'd4;
    localparam logic [2:0] TMR_COUNT_HI  = 3'd5;
    localparam logic [2:0] TMR_STATUS    = 3'd6;
    localparam logic [2:0] TMR_CMD       = 3'd7;

    localparam int unsigned CTRL_EN         = 0;
    localparam int unsigned CTRL_AUTORELOAD = 1;
    localparam int unsigned CTRL_IRQEN      = 2;

    localparam int unsigned STAT_EXPIRED = 0;
    localparam int unsigned STAT_OVERRUN = 1;

    typedef struct packed {
        logic irqen;
        logic autoreload;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/expansion_timer_core.sv
// Prescaler plus 16-bit down counter. A restart reloads the counter and clears the
// prescaler, taking priority over any tick in the same clock.
module timer_core (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        autoreload_i,
    input  logic [7:0]  presc_i,
    input  logic [15:0] reload_i,
    input  logic        restart_i,
    output logic [15:0] count_o,
    output logic        expire_pulse_o
);

    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] count_q, count_d;
    logic        tick;

    always_comb begin
        pcnt_d         = pcnt_q;
        count_d        = count_q;
        expire_pulse_o = 1'b0;
        tick           = en_i && (pcnt_q == presc_i);
        if (restart_i) begin
            pcnt_d  = '0;
            count_d = reload_i;
        end else if (en_i) begin
            pcnt_d = tick ? '0 : pcnt_q + 8'd1;
            if (tick) begin
                if (count_q != '0) begin
                    count_d        = count_q - 16'd1;
                    expire_pulse_o = (count_q == 16'd1);
                end else if (autoreload_i) begin
                    count_d = reload_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q  <= '0;
            count_q <= '0;
        end else begin
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/expansion_timer.sv
// IO-bus responder for the countdown timer card: address decode, strobe edge detection,
// register file, atomic count snapshot and sticky status with interrupt output.
module expansion_timer
    import expansion_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic       i_clkDesign,
    input  logic       i_resetn,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic       i_ioSelect,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    output logic       o_irq
);

    logic        hit;
    logic [2:0]  off;
    logic        rd_strobe;
    logic        wr_commit;
    logic        rd_end;
    logic        restart;
    logic [15:0] count;
    logic        expire_pulse;
    logic [7:0]  rd_data;

    logic        we_act_q;
    logic        rd_act_q;
    logic [2:0]  rd_off_q;
    ctrl_t       ctrl_q, ctrl_d;
    logic [7:0]  presc_q, presc_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] snap_q, snap_d;
    logic [7:0]  snap_hi_q, snap_hi_d;
    logic        expired_q, expired_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;

    assign hit       = i_ioSelect && (i_ioAddress[7:3] == BASE_ADDR[7:3]);
    assign off       = i_ioAddress[2:0];
    assign rd_strobe = hit && !i_ioNOE;
    // we_act_q resets to "strobe already active" so a strobe held across reset never commits.
    assign wr_commit = hit && !i_ioNWE && !we_act_q;
    assign rd_end    = rd_act_q && i_ioNOE;
    assign restart   = wr_commit && (off == TMR_CMD);

    timer_core u_core (
        .clk_i          (i_clkDesign),
        .rst_ni         (i_resetn),
        .en_i           (ctrl_q.en),
        .autoreload_i   (ctrl_q.autoreload),
        .presc_i        (presc_q),
        .reload_i       (reload_q),
        .restart_i      (restart),
        .count_o        (count),
        .expire_pulse_o (expire_pulse)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        expired_d = expired_q;
        overrun_d = overrun_q;
        if (wr_commit) begin
            case (off)
                TMR_CTRL: begin
                    ctrl_d.en         = i_bus[CTRL_EN];
                    ctrl_d.autoreload = i_bus[CTRL_AUTORELOAD];
                    ctrl_d.irqen      = i_bus[CTRL_IRQEN];
                end
                TMR_PRESC:     presc_d         = i_bus;
                TMR_RELOAD_LO: reload_d[7:0]   = i_bus;
                TMR_RELOAD_HI: reload_d[15:8]  = i_bus;
                default: ;
            endcase
        end
        // A clearing read loses to a simultaneous expiry; OVERRUN then keeps its old value.
        if (rd_end && (rd_off_q == TMR_STATUS)) begin
            expired_d = expire_pulse;
            overrun_d = expire_pulse ? overrun_q : 1'b0;
        end else if (expire_pulse) begin
            expired_d = 1'b1;
            overrun_d = overrun_q | expired_q;
        end
        snap_d    = (rd_strobe && (off == TMR_COUNT_LO)) ? snap_q : count;
        snap_hi_d = (rd_end && (rd_off_q == TMR_COUNT_LO)) ? snap_q[15:8] : snap_hi_q;
        irq_d     = expired_d && ctrl_d.irqen;
    end

    always_ff @(posedge i_clkDesign or negedge i_resetn) begin
        if (!i_resetn) begin
            we_act_q  <= 1'b1;
            rd_act_q  <= 1'b0;
            rd_off_q  <= '0;
            ctrl_q    <= '0;
            presc_q   <= '0;
            reload_q  <= '0;
            snap_q    <= '0;
            snap_hi_q <= '0;
            expired_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            we_act_q  <= !i_ioNWE;
            rd_act_q  <= rd_strobe;
            if (rd_strobe) begin
                rd_off_q <= off;
            end
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            reload_q  <= reload_d;
            snap_q    <= snap_d;
            snap_hi_q <= snap_hi_d;
            expired_q <= expired_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            TMR_CTRL:      rd_data = {5'b0, ctrl_q};
            TMR_PRESC:     rd_data = presc_q;
            TMR_RELOAD_LO: rd_data = reload_q[7:0];
            TMR_RELOAD_HI: rd_data = reload_q[15:8];
            TMR_COUNT_LO:  rd_data = snap_q[7:0];
            TMR_COUNT_HI:  rd_data = snap_hi_q;
            TMR_STATUS: begin
                rd_data[STAT_EXPIRED] = expired_q;
                rd_data[STAT_OVERRUN] = overrun_q;
            end
            default:       rd_data = '0;
        endcase
    end

    assign o_busNOE = !rd_strobe;
    assign o_bus    = rd_strobe ? rd_data : '0;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_expansion_timer.sv
// Self-checking bench for expansion_timer: directed scenarios with literal expectations plus
// a randomized bus sequence compared every clock against a behavioural model.
module tb_expansion_timer;

    localparam logic [7:0] BASE = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] bus_i = '0;
    logic [7:0] bus_o;
    logic       noe_o;
    logic       sel = 1'b0;
    logic [7:0] addr = '0;
    logic       noe = 1'b1;
    logic       nwe = 1'b1;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    expansion_timer #(.BASE_ADDR(BASE)) dut (
        .i_clkDesign (clk),
        .i_resetn    (rst_n),
        .i_bus       (bus_i),
        .o_bus       (bus_o),
        .o_busNOE    (noe_o),
        .i_ioSelect  (sel),
        .i_ioAddress (addr),
        .i_ioNOE     (noe),
        .i_ioNWE     (nwe),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_ctrl = '0;
    logic [7:0]  m_presc = '0;
    logic [15:0] m_reload = '0;
    logic [15:0] m_count = '0;
    logic [7:0]  m_pcnt = '0;
    logic [15:0] m_snap = '0;
    logic [7:0]  m_snap_hi = '0;
    bit          m_exp = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_irq = 1'b0;
    bit          m_we_seen = 1'b1;
    bit          m_prev_rd = 1'b0;
    logic [2:0]  m_rd_off = '0;

    function automatic bit in_win();
        return sel && (int'(addr) >= int'(BASE)) && (int'(addr) < int'(BASE) + 8);
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_presc = '0; m_reload = '0; m_count = '0; m_pcnt = '0;
        m_snap = '0; m_snap_hi = '0; m_exp = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
        m_we_seen = 1'b1; m_prev_rd = 1'b0; m_rd_off = '0;
    endtask

    task automatic model_step();
        bit hit, wr, rd_now, rd_end, expire;
        logic [2:0] o;
        logic [15:0] old_count;
        hit = in_win();
        o = addr[2:0];
        wr = hit && !nwe && !m_we_seen;
        rd_now = hit && !noe;
        rd_end = m_prev_rd && noe;
        expire = 1'b0;
        old_count = m_count;
        if (wr && o == 3'd7) begin
            m_count = m_reload;
            m_pcnt = 8'd0;
        end else if (m_ctrl[0]) begin
            if (m_pcnt == m_presc) begin
                m_pcnt = 8'd0;
                if (m_count > 0) begin
                    expire = (m_count == 16'd1);
                    m_count = m_count - 16'd1;
                end else if (m_ctrl[1]) begin
                    m_count = m_reload;
                end
            end else begin
                m_pcnt = m_pcnt + 8'd1;
            end
        end
        if (rd_end && m_rd_off == 3'd6) begin
            if (!expire) m_ovr = 1'b0;
            m_exp = expire;
        end else if (expire) begin
            if (m_exp) m_ovr = 1'b1;
            m_exp = 1'b1;
        end
        if (rd_end && m_rd_off == 3'd4) m_snap_hi = m_snap[15:8];
        if (!(rd_now && o == 3'd4)) m_snap = old_count;
        if (wr) begin
            case (o)
                3'd0: m_ctrl = bus_i[2:0];
                3'd1: m_presc = bus_i;
                3'd2: m_reload = {m_reload[15:8], bus_i};
                3'd3: m_reload = {bus_i, m_reload[7:0]};
                default: ;
            endcase
        end
        m_irq = m_exp && m_ctrl[2];
        m_we_seen = !nwe;
        m_prev_rd = rd_now;
        if (rd_now) m_rd_off = o;
    endtask

    function automatic logic [7:0] exp_bus();
        if (!(in_win() && !noe)) return 8'h00;
        case (addr[2:0])
            3'd0: return {5'b0, m_ctrl};
            3'd1: return m_presc;
            3'd2: return m_reload[7:0];
            3'd3: return m_reload[15:8];
            3'd4: return m_snap[7:0];
            3'd5: return m_snap_hi;
            3'd6: return {6'b0, m_ovr, m_exp};
            default: return 8'h00;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("irq", {15'b0, irq}, {15'b0, m_irq});
            chk("busNOE", {15'b0, noe_o}, {15'b0, !(in_win() && !noe)});
            chk("bus", {8'b0, bus_o}, {8'b0, exp_bus()});
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold = 1, input bit s = 1'b1);
        @(posedge clk); #1;
        sel = s; addr = a; bus_i = d; nwe = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        nwe = 1'b1; sel = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, input bit s = 1'b1, input int hold = 1);
        @(posedge clk); #1;
        sel = s; addr = a; noe = 1'b0;
        #3;
        d = bus_o;
        repeat (hold) @(posedge clk);
        #1;
        noe = 1'b1; sel = 1'b0;
    endtask

    task automatic wait_irq(input int lim, output int n);
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk); #1;
            if (irq) begin
                n = k;
                break;
            end
        end
    endtask

    function automatic logic [7:0] ra(input logic [2:0] o);
        return {BASE[7:3], o};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d, d2, v;
        int n, c0, c1, c2, op, hold;
        logic [2:0] o;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        chk("idle_irq", {15'b0, irq}, 16'h0);
        chk("idle_noe", {15'b0, noe_o}, 16'h1);
        rd(ra(3'd0), d);  chk("rst_ctrl", {8'b0, d}, 16'h00);
        rd(ra(3'd6), d);  chk("rst_status", {8'b0, d}, 16'h00);

        // periodic expiry, status and overrun
        wr(ra(3'd1), 8'd3);
        wr(ra(3'd2), 8'h05);
        wr(ra(3'd3), 8'h00);
        wr(ra(3'd0), 8'h07);
        wr(ra(3'd7), 8'h00);
        c0 = cyc;
        wait_irq(100, n);
        c1 = cyc;
        chk("first_expiry", 16'(c1 - c0), 16'd20);
        rd(ra(3'd6), d);  chk("status_expired", {8'b0, d}, 16'h01);
        wait_irq(100, n);
        c2 = cyc;
        chk("expiry_period", 16'(c2 - c1), 16'd24);
        repeat (30) @(posedge clk);
        rd(ra(3'd6), d);  chk("status_overrun", {8'b0, d}, 16'h03);
        rd(ra(3'd6), d);  chk("status_cleared", {8'b0, d}, 16'h00);
        @(posedge clk); #1;
        chk("irq_dropped", {15'b0, irq}, 16'h0);

        // atomic 16-bit read across 0x0100 -> 0x00FF
        wr(ra(3'd0), 8'h00);
        wr(ra(3'd1), 8'd3);
        wr(ra(3'd2), 8'h01);
        wr(ra(3'd3), 8'h01);
        wr(ra(3'd0), 8'h01);
        wr(ra(3'd7), 8'h00);
        repeat (5) @(posedge clk);
        rd(ra(3'd4), d);
        rd(ra(3'd5), d2);
        chk("atomic_pair", {d2, d}, 16'h0100);

        // held CMD strobe restarts once
        wr(ra(3'd0), 8'h00);
        wr(ra(3'd1), 8'd0);
        wr(ra(3'd2), 8'h00);
        wr(ra(3'd3), 8'h02);
        wr(ra(3'd0), 8'h01);
        wr(ra(3'd7), 8'h00, 10);
        rd(ra(3'd4), d);
        rd(ra(3'd5), d2);
        chk("held_cmd_count", {d2, d}, 16'h01F7);

        // decode: out of window and deselected cycles touch nothing
        wr(8'h19, 8'h55);
        wr(8'h0F, 8'h55);
        wr(ra(3'd0), 8'h06, 1, 1'b0);
        rd(8'h18, d);            chk("outwin_read", {8'b0, d}, 16'h00);
        rd(ra(3'd0), d, 1'b0);   chk("desel_read", {8'b0, d}, 16'h00);
        rd(ra(3'd0), d);         chk("ctrl_kept", {8'b0, d}, 16'h01);
        rd(ra(3'd1), d);         chk("presc_kept", {8'b0, d}, 16'h00);

        // randomized traffic against the model
        wr(ra(3'd1), 8'd1);
        wr(ra(3'd2), 8'd4);
        wr(ra(3'd0), 8'h07);
        wr(ra(3'd7), 8'h00);
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 9));
            o = 3'($urandom_range(0, 7));
            v = 8'($urandom);
            hold = int'($urandom_range(1, 3));
            case (op)
                0, 1, 2: begin
                    if (o == 3'd1) v = 8'($urandom_range(0, 3));
                    if (o == 3'd2) v = 8'($urandom_range(0, 7));
                    if (o == 3'd3 && $urandom_range(0, 7) != 0) v = 8'h00;
                    wr(ra(o), v, hold);
                end
                3, 4, 5: rd(ra(o), d, 1'b1, hold);
                6:       wr(8'($urandom), v);
                7:       rd(8'($urandom), d, 1'($urandom));
                8:       repeat ($urandom_range(1, 12)) @(posedge clk);
                default: wr(ra(o), v, 1, 1'b0);
            endcase
        end

        // async reset mid-count and mid-strobe
        wr(ra(3'd0), 8'h00);
        rd(ra(3'd6), d);
        wr(ra(3'd1), 8'd0);
        wr(ra(3'd2), 8'h02);
        wr(ra(3'd3), 8'h00);
        wr(ra(3'd0), 8'h07);
        wr(ra(3'd7), 8'h00);
        wait_irq(20, n);
        chk("fast_expiry", 16'(n), 16'd2);
        @(posedge clk); #1;
        sel = 1'b1; addr = ra(3'd1); bus_i = 8'h5A; nwe = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_irq", {15'b0, irq}, 16'h0);
        chk("async_noe", {15'b0, noe_o}, 16'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nwe = 1'b1; sel = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rd(ra(3'(k)), d);
            chk("post_reset_reg", {8'b0, d}, 16'h00);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
